alu_rr_scheduler: RTL

//  Shares one combinational 2-bit ALU between NUM_REQ requesters using round-robin arbitration.

---
 rtl/alu_rr_scheduler.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/alu_rr_scheduler.sv
// -----------------------------------------------------------------------------
// alu_rr_scheduler
//   Shares one external combinational ALU between NUM_REQ requesters using
//   round-robin arbitration. A request is accepted in IDLE, its operands are
//   registered onto the ALU inputs, the ALU result and flags are captured one
//   cycle later (EXEC), and are presented on a single response channel tagged
//   with the requester ID (RESP) until the consumer accepts them.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready  per-requester handshake; req_ready is one-hot or 0
//   req_a / req_b          packed operands, requester i at [i*DATA_W +: DATA_W]
//   req_sel                packed opcodes, requester i at [i*SEL_W +: SEL_W]
//   alu_a / alu_b / alu_sel  registered operands/opcode driven to the ALU
//   alu_out / alu_flags    ALU result and {error,zero,carry,overflow}
//   rsp_valid / rsp_ready  response handshake
//   rsp_id / rsp_out / rsp_flags  captured response fields
//   err_count              saturating count of responses with error=1
// -----------------------------------------------------------------------------
module alu_rr_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 2,
    parameter int SEL_W   = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]  req_a,
    input  logic [NUM_REQ*DATA_W-1:0]  req_b,
    input  logic [NUM_REQ*SEL_W-1:0]   req_sel,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    output logic [SEL_W-1:0]           alu_sel,
    input  logic [DATA_W-1:0]          alu_out,
    input  logic [3:0]                 alu_flags,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [DATA_W-1:0]          rsp_out,
    output logic [3:0]                 rsp_flags,
    output logic [7:0]                 err_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [SEL_W-1:0]    alu_sel_q, alu_sel_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_out_q, rsp_out_d;
    logic [3:0]          rsp_flags_q, rsp_flags_d;
    logic [7:0]          err_count_q, err_count_d;

    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    logic [DATA_W-1:0]   grant_a;
    logic [DATA_W-1:0]   grant_b;
    logic [SEL_W-1:0]    grant_sel;
    int                  scan_idx;

    // Round-robin search: start one past the last grant and wrap, so the most
    // recently served requester has the lowest priority.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so
        // no path leaves it unassigned and no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            scan_idx = int'(ptr_q) + i;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!grant_found && req_valid[ID_W'(scan_idx)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(scan_idx);
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        grant_a   = '0;
        grant_b   = '0;
        grant_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                grant_a   = req_a[i*DATA_W +: DATA_W];
                grant_b   = req_b[i*DATA_W +: DATA_W];
                grant_sel = req_sel[i*SEL_W +: SEL_W];
            end
        end
    end

    // Ready only ever appears in IDLE; RESP refuses new work even on the
    // handshake cycle.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state and datapath updates; everything holds unless the state
    // calls for a change.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_id_d    = rsp_id_q;
        rsp_out_d   = rsp_out_q;
        rsp_flags_d = rsp_flags_q;
        err_count_d = err_count_q;

        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    alu_a_d   = grant_a;
                    alu_b_d   = grant_b;
                    alu_sel_d = grant_sel;
                    rsp_id_d  = grant_idx;
                    ptr_d     = grant_idx;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                // The ALU has had a full cycle to settle from the registered
                // operands; capture its result and flags as-is.
                rsp_out_d   = alu_out;
                rsp_flags_d = alu_flags;
                if (alu_flags[3] && err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_id_q    <= '0;
            rsp_out_q   <= '0;
            rsp_flags_q <= '0;
            err_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_id_q    <= rsp_id_d;
            rsp_out_q   <= rsp_out_d;
            rsp_flags_q <= rsp_flags_d;
            err_count_q <= err_count_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_flags = rsp_flags_q;
    assign err_count = err_count_q;

endmodule
